// File: rtl/sorter_host_ctrl.sv
// rtl/sorter_host_ctrl.sv - host initiator: streams a batch into the Sorter, starts it, streams it back sorted
// Optional SORTER_HOST_CHECK_EN adds sort_err, a sticky order check on the unloaded stream.
module sorter_host_ctrl #(
  parameter int AW = 3,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          s_start,
  output logic          s_wr,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_datain,
  input  logic          s_ready,
  input  logic [DW-1:0] s_dataout,
  output logic          busy,
  output logic [15:0]   sort_cycles
`ifdef SORTER_HOST_CHECK_EN
  ,
  output logic          sort_err
`endif
);

  typedef enum logic [2:0] {
    ST_LOAD, ST_START, ST_BUSY, ST_DONE, ST_UNLOAD, ST_FETCH, ST_HOLD
  } state_t;

  localparam logic [AW-1:0] K_LAST = '1;

  state_t        state;
  logic [AW-1:0] k;
  logic [15:0]   count;
`ifdef SORTER_HOST_CHECK_EN
  logic [DW-1:0] prev_data;
`endif

  always_comb begin
    in_ready = (state == ST_LOAD);
    s_wr     = (state == ST_LOAD) && in_valid;
    s_datain = in_data;
    s_addr   = k;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= ST_LOAD;
      k           <= '0;
      count       <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      s_start     <= 1'b0;
      busy        <= 1'b0;
      sort_cycles <= '0;
`ifdef SORTER_HOST_CHECK_EN
      prev_data   <= '0;
      sort_err    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_LOAD: begin
          if (in_valid) begin
            if (k == K_LAST) begin
              k     <= '0;
              state <= ST_START;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        ST_START: begin
          // Only start a Sorter that reports ready; the pulse lands in the first BUSY cycle.
          if (s_ready) begin
            s_start <= 1'b1;
            busy    <= 1'b1;
            count   <= '0;
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          s_start <= 1'b0;
          if (count != 16'hFFFF) count <= count + 16'd1;
          if (!s_ready) state <= ST_DONE;
        end
        ST_DONE: begin
          if (count != 16'hFFFF) count <= count + 16'd1;
          if (s_ready) begin
            busy        <= 1'b0;
            sort_cycles <= count;
            state       <= ST_UNLOAD;
          end
        end
        ST_UNLOAD: state <= ST_FETCH;
        ST_FETCH: begin
          out_data  <= s_dataout;
          out_valid <= 1'b1;
          state     <= ST_HOLD;
`ifdef SORTER_HOST_CHECK_EN
          if ((k != '0) && (s_dataout < prev_data)) sort_err <= 1'b1;
          prev_data <= s_dataout;
`endif
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (k == K_LAST) begin
              k     <= '0;
              state <= ST_LOAD;
            end else begin
              k     <= k + 1'b1;
              state <= ST_UNLOAD;
            end
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_sorter_host_ctrl.sv
// tb/tb_sorter_host_ctrl.sv - scoreboard bench for sorter_host_ctrl with a behavioural Sorter model
module tb_sorter_host_ctrl;

  typedef logic [7:0] arr8_t [8];

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b1;
  logic       s_start;
  logic       s_wr;
  logic [2:0] s_addr;
  logic [7:0] s_datain;
  logic       s_ready;
  logic [7:0] s_dataout;
  logic       busy;
  logic [15:0] sort_cycles;
`ifdef SORTER_HOST_CHECK_EN
  logic       sort_err;
`endif

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  int hold_len = 12;
  logic faulty = 1'b0;
  arr8_t mem;
  int rem;
  int start_cnt = 0;
  int wr_cnt = 0;
  int inv_viol = 0;

  always #5 clk = ~clk;

  sorter_host_ctrl #(.AW(3), .DW(8)) dut (
    .clk(clk), .nrst(nrst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .s_start(s_start), .s_wr(s_wr), .s_addr(s_addr), .s_datain(s_datain),
    .s_ready(s_ready), .s_dataout(s_dataout),
    .busy(busy), .sort_cycles(sort_cycles)
`ifdef SORTER_HOST_CHECK_EN
    , .sort_err(sort_err)
`endif
  );

  function automatic arr8_t sort8(input arr8_t a);
    arr8_t r = a;
    logic [7:0] t;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 7 - i; j++)
        if (r[j] > r[j+1]) begin t = r[j]; r[j] = r[j+1]; r[j+1] = t; end
    return r;
  endfunction

  // Sorter model: ready drops after start for hold_len cycles, RAM read has 1-cycle latency.
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s_ready   <= 1'b1;
      s_dataout <= 8'd0;
      rem       <= 0;
    end else begin
      s_dataout <= mem[s_addr];
      if (s_wr) mem[s_addr] <= s_datain;
      if (s_start) begin
        s_ready <= 1'b0;
        rem     <= hold_len;
      end else if (!s_ready) begin
        if (rem <= 1) begin
          s_ready <= 1'b1;
          if (faulty) mem <= '{8'd1, 8'd2, 8'd4, 8'd3, 8'd5, 8'd6, 8'd7, 8'd8};
          else        mem <= sort8(mem);
        end else begin
          rem <= rem - 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (nrst && s_start) start_cnt <= start_cnt + 1;
    if (nrst && s_wr) wr_cnt <= wr_cnt + 1;
  end

  always @(negedge clk)
    if (nrst && ((s_wr && s_start) || (s_wr && !in_ready))) inv_viol <= inv_viol + 1;

  task automatic load_batch(input arr8_t w, input int max_gap, input bit push_exp);
    logic [7:0] s[$];
    int n;
    for (int i = 0; i < 8; i++) begin
      int gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
      repeat (gap) begin in_valid = 1'b0; @(negedge clk); end
      in_valid = 1'b1;
      in_data  = w[i];
      n = 0;
      while (!in_ready && n < 200) begin @(negedge clk); n++; end
      tests++;
      if (n >= 200) begin fails++; $display("FAIL load_accept word %0d: in_ready=%0b required 1", i, in_ready); end
      @(negedge clk);
      s.push_back(w[i]);
    end
    in_valid = 1'b0;
    s.sort();
    if (push_exp) foreach (s[j]) exp_q.push_back(s[j]);
  endtask

  task automatic wait_sort(input int exp_cycles);
    int n = 0, rise = -1, fall = -1, st0 = start_cnt;
    logic prev_r = 1'b1, seen_busy = 1'b0;
    while (!out_valid && n < 3000) begin
      @(negedge clk); n++;
      if (busy) seen_busy = 1'b1;
      if (s_ready && !prev_r && rise < 0) rise = n;
      if (!busy && seen_busy && fall < 0) fall = n;
      prev_r = s_ready;
    end
    tests++;
    if (n >= 3000) begin fails++; $display("FAIL sort_timeout: out_valid=%0b required 1", out_valid); end
    tests++;
    if (fall != rise + 1 || rise < 0) begin fails++; $display("FAIL busy_fall: fell at %0d, ready rose at %0d", fall, rise); end
    tests++;
    if (start_cnt - st0 !== 1) begin fails++; $display("FAIL start_pulses: got %0d required 1", start_cnt - st0); end
    tests++;
    if (sort_cycles !== exp_cycles[15:0]) begin fails++; $display("FAIL sort_cycles: got %0d required %0d", sort_cycles, exp_cycles); end
  endtask

  task automatic unload_batch(input int mode, input bit chk_err);
    int beats = 0, n = 0, cyc = 0;
    logic [7:0] held = 8'd0, e;
    logic stalled = 1'b0;
    while (beats < 8 && n < 3000) begin
      out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      cyc++;
      if (stalled && out_valid) begin
        tests++;
        if (out_data !== held) begin fails++; $display("FAIL stall_stable: got %0d required %0d", out_data, held); end
      end
      if (out_valid && out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        tests++;
        if (out_data !== e) begin fails++; $display("FAIL out_beat %0d: got %0d required %0d", beats, out_data, e); end
`ifdef SORTER_HOST_CHECK_EN
        if (chk_err) begin
          tests++;
          if (sort_err !== (beats >= 3)) begin fails++; $display("FAIL sort_err beat %0d: got %0b required %0b", beats, sort_err, beats >= 3); end
        end
`endif
        beats++;
        stalled = 1'b0;
      end else if (out_valid) begin
        stalled = 1'b1;
        held = out_data;
      end else begin
        stalled = 1'b0;
      end
      @(negedge clk); n++;
    end
    out_ready = 1'b1;
    tests++;
    if (beats != 8) begin fails++; $display("FAIL unload_timeout: beats %0d required 8", beats); end
    repeat (4) begin
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        fails++; $display("FAIL after_unload: out_valid=%0b in_ready=%0b required 0/1", out_valid, in_ready);
      end
      @(negedge clk);
    end
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL leftover_expected: %0d words required 0", exp_q.size()); end
    if (chk_err) n = 0;
  endtask

  task automatic test_reset;
    tests++;
    if (out_valid !== 1'b0 || out_data !== 8'd0 || s_start !== 1'b0 || busy !== 1'b0 || sort_cycles !== 16'd0) begin
      fails++; $display("FAIL reset_outputs: ov=%0b od=%0d st=%0b busy=%0b sc=%0d required all 0", out_valid, out_data, s_start, busy, sort_cycles);
    end
    tests++;
    if (in_ready !== 1'b1 || s_wr !== 1'b0 || s_addr !== 3'd0) begin
      fails++; $display("FAIL reset_load: in_ready=%0b s_wr=%0b s_addr=%0d required 1/0/0", in_ready, s_wr, s_addr);
    end
  endtask

  task automatic test_basic;
    hold_len = 12;
    load_batch('{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 0, 1'b1);
    wait_sort(13);
    unload_batch(0, 1'b0);
  endtask

  task automatic test_gaps;
    int w0 = wr_cnt;
    hold_len = 7;
    load_batch('{8'd5, 8'd5, 8'd0, 8'd255, 8'd5, 8'd0, 8'd255, 8'd1}, 3, 1'b1);
    wait_sort(8);
    tests++;
    if (wr_cnt - w0 !== 8) begin fails++; $display("FAIL write_count: got %0d required 8", wr_cnt - w0); end
    unload_batch(0, 1'b0);
  endtask

  task automatic test_backpressure;
    hold_len = 5;
    load_batch('{8'd2, 8'd8, 8'd1, 8'd7, 8'd3, 8'd6, 8'd4, 8'd5}, 1, 1'b1);
    wait_sort(6);
    unload_batch(1, 1'b0);
  endtask

  task automatic test_reset_mid;
    int n = 0;
    hold_len = 30;
    load_batch('{8'd9, 8'd4, 8'd6, 8'd1, 8'd3, 8'd2, 8'd8, 8'd7}, 0, 1'b0);
    while (!busy && n < 100) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_data !== 8'd0 || s_start !== 1'b0 || busy !== 1'b0 || sort_cycles !== 16'd0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_mid: ov=%0b od=%0d st=%0b busy=%0b sc=%0d ir=%0b required 0/0/0/0/0/1",
                        out_valid, out_data, s_start, busy, sort_cycles, in_ready);
    end
    exp_q.delete();
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    hold_len = 10;
    load_batch('{8'd3, 8'd1, 8'd2, 8'd7, 8'd0, 8'd6, 8'd5, 8'd4}, 0, 1'b1);
    wait_sort(11);
    unload_batch(0, 1'b0);
  endtask

  task automatic test_long_sort;
    hold_len = 40;
    load_batch('{8'd200, 8'd100, 8'd50, 8'd25, 8'd12, 8'd6, 8'd3, 8'd1}, 0, 1'b1);
    wait_sort(41);
    unload_batch(0, 1'b0);
  endtask

`ifdef SORTER_HOST_CHECK_EN
  task automatic test_check_err;
    hold_len = 6;
    faulty = 1'b1;
    tests++;
    if (sort_err !== 1'b0) begin fails++; $display("FAIL sort_err_pre: got %0b required 0", sort_err); end
    load_batch('{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 0, 1'b0);
    foreach (mem[i]) exp_q.push_back(8'(i + 1));
    exp_q[2] = 8'd4;
    exp_q[3] = 8'd3;
    wait_sort(7);
    unload_batch(0, 1'b1);
    tests++;
    if (sort_err !== 1'b1) begin fails++; $display("FAIL sort_err_sticky: got %0b required 1", sort_err); end
    faulty = 1'b0;
  endtask
`endif

  initial begin
    repeat (2) @(negedge clk);
    test_reset;
    nrst = 1'b1;
    @(negedge clk);
    test_reset;
    test_basic;
    test_gaps;
    test_backpressure;
    test_reset_mid;
    test_long_sort;
`ifdef SORTER_HOST_CHECK_EN
    test_check_err;
`endif
    tests++;
    if (inv_viol != 0) begin fails++; $display("FAIL write_invariant: %0d violations required 0", inv_viol); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
